// File: rtl/lab1_imul_pkg.sv
// Shared definitions for the lab1 iterative integer multiplier.
// Holds the result-mode encodings and the control FSM state type.
package lab1_imul_pkg;

    localparam logic [1:0] IMUL_MUL    = 2'd0;
    localparam logic [1:0] IMUL_MULH   = 2'd1;
    localparam logic [1:0] IMUL_MULHSU = 2'd2;
    localparam logic [1:0] IMUL_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        IMUL_IDLE,
        IMUL_CALC,
        IMUL_DONE
    } imul_state_e;

endpackage

// File: rtl/lab1_imul_int_mul_param_dpath.sv
// Shift-add datapath: operand magnitudes, accumulator, iteration count,
// final sign fix-up and selection of the requested product half.
module lab1_imul_int_mul_param_dpath
    import lab1_imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_done,
    input  logic [NBITS-1:0] i_a,
    input  logic [NBITS-1:0] i_b,
    input  logic [1:0]       i_mode,
    output logic             o_b_is_zero_next,
    output logic             o_cnt_last,
    output logic [NBITS-1:0] o_result
);

    localparam int W  = 2 * NBITS;
    localparam int CW = $clog2(NBITS + 1);

    logic [W-1:0]     r_a;
    logic [NBITS-1:0] r_b;
    logic [W-1:0]     r_acc;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_mode;
    logic             r_neg;
    logic [NBITS-1:0] r_result;

    logic             w_a_sgn;
    logic             w_b_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [NBITS-1:0] w_a_abs;
    logic [NBITS-1:0] w_b_abs;
    logic [NBITS-1:0] w_b_next;
    logic [W-1:0]     w_acc_next;
    logic [W-1:0]     w_prod;
    logic [NBITS-1:0] w_half;

    // Most-negative operands negate onto themselves, which is the
    // correct unsigned magnitude, so no overflow handling is needed.
    assign w_a_sgn = (i_mode != IMUL_MULHU);
    assign w_b_sgn = (i_mode == IMUL_MUL) || (i_mode == IMUL_MULH);
    assign w_a_neg = w_a_sgn & i_a[NBITS-1];
    assign w_b_neg = w_b_sgn & i_b[NBITS-1];
    assign w_a_abs = w_a_neg ? -i_a : i_a;
    assign w_b_abs = w_b_neg ? -i_b : i_b;

    assign w_b_next   = r_b >> 1;
    assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_prod     = r_neg ? -w_acc_next : w_acc_next;
    assign w_half     = (r_mode == IMUL_MUL) ? w_prod[NBITS-1:0]
                                             : w_prod[W-1:NBITS];

    assign o_b_is_zero_next = (w_b_next == '0);
    assign o_cnt_last       = (r_cnt == CW'(NBITS - 1));
    assign o_result         = r_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mode   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_a    <= {{NBITS{1'b0}}, w_a_abs};
                r_b    <= w_b_abs;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_mode <= i_mode;
                r_neg  <= w_a_neg ^ w_b_neg;
            end else if (i_step) begin
                r_a    <= r_a << 1;
                r_b    <= w_b_next;
                r_acc  <= w_acc_next;
                r_cnt  <= r_cnt + CW'(1);
            end
            if (i_done) begin
                r_result <= w_half;
            end
        end
    end

endmodule

// File: rtl/lab1_imul_int_mul_param.sv
// Variable-latency iterative multiplier with val/rdy request and response
// ports; control FSM here, arithmetic in the dpath sub-module.
module lab1_imul_int_mul_param
    import lab1_imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_msg_a,
    input  logic [NBITS-1:0] req_msg_b,
    input  logic [1:0]       req_msg_mode,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg_result
);

    imul_state_e r_state;
    logic        r_req_rdy;
    logic        r_resp_val;

    logic w_load;
    logic w_step;
    logic w_done;
    logic w_b_is_zero_next;
    logic w_cnt_last;

    assign w_load = req_val & r_req_rdy & (r_state == IMUL_IDLE);
    assign w_step = (r_state == IMUL_CALC);
    assign w_done = w_step & (w_b_is_zero_next | w_cnt_last);

    assign req_rdy  = r_req_rdy;
    assign resp_val = r_resp_val;

    // Handshake flags are registered so no input reaches an output
    // combinationally; req_rdy rises on the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IMUL_IDLE;
            r_req_rdy  <= 1'b0;
            r_resp_val <= 1'b0;
        end else begin
            unique case (r_state)
                IMUL_IDLE: begin
                    r_req_rdy <= 1'b1;
                    if (w_load) begin
                        r_state   <= IMUL_CALC;
                        r_req_rdy <= 1'b0;
                    end
                end
                IMUL_CALC: begin
                    if (w_done) begin
                        r_state    <= IMUL_DONE;
                        r_resp_val <= 1'b1;
                    end
                end
                IMUL_DONE: begin
                    if (resp_rdy) begin
                        r_state    <= IMUL_IDLE;
                        r_resp_val <= 1'b0;
                        r_req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IMUL_IDLE;
                    r_req_rdy  <= 1'b0;
                    r_resp_val <= 1'b0;
                end
            endcase
        end
    end

    lab1_imul_int_mul_param_dpath #(
        .NBITS(NBITS)
    ) u_dpath (
        .clk              (clk),
        .reset            (reset),
        .i_load           (w_load),
        .i_step           (w_step),
        .i_done           (w_done),
        .i_a              (req_msg_a),
        .i_b              (req_msg_b),
        .i_mode           (req_msg_mode),
        .o_b_is_zero_next (w_b_is_zero_next),
        .o_cnt_last       (w_cnt_last),
        .o_result         (resp_msg_result)
    );

endmodule

// File: tb/tb_lab1_imul_int_mul_param.sv
// Directed and randomised checks of the iterative multiplier at 32 and 8 bits
// against a wide-arithmetic reference and an expected-latency table.
module tb_lab1_imul_int_mul_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_msg_a;
    logic [31:0] req_msg_b;
    logic [1:0]  req_msg_mode;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg_result;

    logic        req_val8;
    logic        req_rdy8;
    logic [7:0]  req_msg_a8;
    logic [7:0]  req_msg_b8;
    logic [1:0]  req_msg_mode8;
    logic        resp_val8;
    logic        resp_rdy8;
    logic [7:0]  resp_msg_result8;

    int ncmp  = 0;
    int nfail = 0;

    logic [31:0] q32[$];
    logic [7:0]  q8[$];

    lab1_imul_int_mul_param #(.NBITS(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_msg_a       (req_msg_a),
        .req_msg_b       (req_msg_b),
        .req_msg_mode    (req_msg_mode),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_msg_result (resp_msg_result)
    );

    lab1_imul_int_mul_param #(.NBITS(8)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val8),
        .req_rdy         (req_rdy8),
        .req_msg_a       (req_msg_a8),
        .req_msg_b       (req_msg_b8),
        .req_msg_mode    (req_msg_mode8),
        .resp_val        (resp_val8),
        .resp_rdy        (resp_rdy8),
        .resp_msg_result (resp_msg_result8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits with its signedness and
    // take the wrapped 64-bit product (n <= 32).
    function automatic logic [63:0] gold(input int n, input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [1:0] m);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        logic [63:0] mask;
        logic        sa;
        logic        sb;
        mask = (64'd1 << n) - 64'd1;
        sa   = (m != 2'd3);
        sb   = (m == 2'd0) || (m == 2'd1);
        ea   = a & mask;
        eb   = b & mask;
        if (sa && a[n-1]) ea = ea | ~mask;
        if (sb && b[n-1]) eb = eb | ~mask;
        p = ea * eb;
        if (m == 2'd0) return p & mask;
        return (p >> n) & mask;
    endfunction

    function automatic int ncalc(input int n, input logic [63:0] b,
                                 input logic [1:0] m);
        logic [63:0] mask;
        logic [63:0] babs;
        int          nc;
        mask = (64'd1 << n) - 64'd1;
        babs = b & mask;
        if (((m == 2'd0) || (m == 2'd1)) && b[n-1]) babs = (-babs) & mask;
        nc = 1;
        for (int i = 0; i < n; i++) if (babs[i]) nc = i + 1;
        return nc;
    endfunction

    task automatic do32(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input int hold);
        int          w;
        int          lat;
        int          nc;
        logic [31:0] first;
        logic [31:0] exp;
        req_msg_a    = a;
        req_msg_b    = b;
        req_msg_mode = m;
        req_val      = 1'b1;
        w = 0;
        while (!req_rdy && w < 100) begin
            tick();
            w++;
        end
        check("req_rdy_wait", {63'd0, (w < 100)}, 64'd1);
        tick();
        req_val = 1'b0;
        q32.push_back(gold(32, {32'd0, a}, {32'd0, b}, m)[31:0]);
        nc = ncalc(32, {32'd0, b}, m);
        check("rdy_in_calc", {63'd0, req_rdy}, 64'd0);
        lat = 0;
        while (!resp_val && lat < 100) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(nc));
        check("rdy_in_done", {63'd0, req_rdy}, 64'd0);
        first = resp_msg_result;
        resp_rdy = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_val", {63'd0, resp_val}, 64'd1);
            check("hold_stable", {32'd0, resp_msg_result}, {32'd0, first});
            check("hold_rdy", {63'd0, req_rdy}, 64'd0);
        end
        exp = q32.pop_front();
        check("result32", {32'd0, resp_msg_result}, {32'd0, exp});
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        check("rdy_after_hs", {63'd0, req_rdy}, 64'd1);
        check("val_after_hs", {63'd0, resp_val}, 64'd0);
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m);
        int         w;
        int         lat;
        logic [7:0] exp;
        req_msg_a8    = a;
        req_msg_b8    = b;
        req_msg_mode8 = m;
        req_val8      = 1'b1;
        w = 0;
        while (!req_rdy8 && w < 100) begin
            tick();
            w++;
        end
        tick();
        req_val8 = 1'b0;
        q8.push_back(gold(8, {56'd0, a}, {56'd0, b}, m)[7:0]);
        lat = 0;
        while (!resp_val8 && lat < 100) begin
            tick();
            lat++;
        end
        check("latency8", 64'(lat), 64'(ncalc(8, {56'd0, b}, m)));
        exp = q8.pop_front();
        check("result8", {56'd0, resp_msg_result8}, {56'd0, exp});
        resp_rdy8 = 1'b1;
        tick();
        resp_rdy8 = 1'b0;
    endtask

    logic [7:0] corner [5];

    initial begin
        reset         = 1'b0;
        req_val       = 1'b0;
        req_msg_a     = '0;
        req_msg_b     = '0;
        req_msg_mode  = '0;
        resp_rdy      = 1'b0;
        req_val8      = 1'b0;
        req_msg_a8    = '0;
        req_msg_b8    = '0;
        req_msg_mode8 = '0;
        resp_rdy8     = 1'b0;
        corner[0] = 8'h00;
        corner[1] = 8'h01;
        corner[2] = 8'h7f;
        corner[3] = 8'h80;
        corner[4] = 8'hff;

        repeat (3) tick();
        check("rst_req_rdy", {63'd0, req_rdy}, 64'd0);
        check("rst_resp_val", {63'd0, resp_val}, 64'd0);
        check("rst_result", {32'd0, resp_msg_result}, 64'd0);
        check("rst_req_rdy8", {63'd0, req_rdy8}, 64'd0);
        reset = 1'b1;
        tick();
        check("rdy_after_rst", {63'd0, req_rdy}, 64'd1);

        do32(32'd3, 32'd4, 2'd0, 0);
        check("mul_3x4", {32'd0, resp_msg_result}, 64'h0000000C);
        do32(32'hFFFFFFFE, 32'd3, 2'd0, 0);
        do32(32'd7, 32'd0, 2'd0, 0);
        do32(32'h80000000, 32'h80000000, 2'd1, 0);
        do32(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 0);
        do32(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd2, 0);
        do32(32'd2, 32'h80000000, 2'd2, 0);
        do32(32'h12345678, 32'h9ABCDEF0, 2'd1, 5);
        do32(32'h80000000, 32'h00000001, 2'd0, 5);
        do32(32'hDEADBEEF, 32'h00000001, 2'd2, 0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            do32($urandom, $urandom >> $urandom_range(0, 31),
                 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        req_msg_a    = 32'd5;
        req_msg_b    = 32'h0000FFFF;
        req_msg_mode = 2'd0;
        req_val      = 1'b1;
        tick();
        req_val = 1'b0;
        repeat (3) tick();
        check("calc_no_val", {63'd0, resp_val}, 64'd0);
        reset = 1'b0;
        #1;
        check("abort_val", {63'd0, resp_val}, 64'd0);
        check("abort_result", {32'd0, resp_msg_result}, 64'd0);
        check("abort_rdy", {63'd0, req_rdy}, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rdy_after_abort", {63'd0, req_rdy}, 64'd1);
        do32(32'd6, 32'd7, 2'd0, 0);
        check("mul_6x7", {32'd0, resp_msg_result}, 64'h0000002A);

        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    do8(corner[i], corner[j], 2'(m));
        for (int k = 0; k < 150; k++)
            do8(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
